// File: rtl/uart_serial_rx.sv
// 8N1 UART receiver with two-flop input synchronizer and a one-deep
// holding register drained by a valid/ready handshake.
module uart_serial_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       uart_serial_com_external_connection_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            sync1;
  logic            rxs;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_serial_com_external_connection_rxd;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state         <= IDLE;
      baud          <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            baud  <= '0;
          end
        end
        START: begin
          if (baud == HALF) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud == BMAX) begin
            baud  <= '0;
            shift <= {rxs, shift[7:1]};
            if (bit_cnt == 3'd7)
              state <= STOP;
            else
              bit_cnt <= bit_cnt + 3'd1;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud == BMAX) begin
            baud <= '0;
            if (rxs) begin
              state <= IDLE;
              // a consume in this same cycle frees the slot
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        BREAK: begin
          if (rxs)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
